button_events: RTL and testbench

BUTTON_EVENTS -- requirements
Module: button_events

---
 rtl/button_events.sv | 135 +++++++++++++
 tb/tb_button_events.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/button_events.sv
// Turns rising edges on debounced buttons into a valid/ready event stream, one
// pending bit per button, round-robin drain. Define BTN_REPEAT_EN for auto-repeat.
module button_events #(
    parameter int N_BTN      = 4,
    parameter int REP_DELAY  = 12000000,
    parameter int REP_PERIOD = 3000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_BTN-1:0]         btn,
    output logic                     ev_valid,
    output logic [$clog2(N_BTN)-1:0] ev_idx,
    input  logic                     ev_ready,
    output logic                     ev_drop
);

    localparam int IW = $clog2(N_BTN);

    logic [N_BTN-1:0] btn_d, btn_q;
    logic [N_BTN-1:0] pending_d, pending_q;
    logic [IW-1:0]    rr_ptr_d, rr_ptr_q;
    logic             ev_valid_d, ev_valid_q;
    logic [IW-1:0]    ev_idx_d, ev_idx_q;
    logic             ev_drop_d, ev_drop_q;

    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] tick;
    logic [N_BTN-1:0] evt;
    logic [N_BTN-1:0] grant_mask;
    logic [IW-1:0]    grant_idx;
    logic             found;
    logic             load;

`ifdef BTN_REPEAT_EN
    localparam int CW = $clog2(REP_DELAY + 1);
    // After the first repeat the counter is rewound so the next match is REP_PERIOD away.
    localparam logic [CW-1:0] CNT_FIRE   = CW'(REP_DELAY);
    localparam logic [CW-1:0] CNT_RELOAD = CW'(REP_DELAY - REP_PERIOD + 1);

    logic [CW-1:0] cnt_d [N_BTN];
    logic [CW-1:0] cnt_q [N_BTN];

    always_comb begin
        tick = '0;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_d[i] = '0;
            if (btn[i]) begin
                if (cnt_q[i] == CNT_FIRE) begin
                    tick[i]  = 1'b1;
                    cnt_d[i] = CNT_RELOAD;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_BTN; i++) begin
            if (rst) begin
                cnt_q[i] <= '0;
            end else begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
`else
    always_comb begin
        tick = '0;
    end
`endif

    // Handshake: an event transfers on a posedge where ev_valid && ev_ready; while
    // ev_valid && !ev_ready the presented ev_idx is held unchanged.
    always_comb begin
        int j;
        btn_d     = btn;
        rise      = btn & ~btn_q;
        evt       = rise | tick;
        found     = 1'b0;
        grant_idx = '0;
        j         = 0;
        for (int off = 0; off < N_BTN; off++) begin
            j = int'(rr_ptr_q) + off;
            if (j >= N_BTN) begin
                j = j - N_BTN;
            end
            if (!found && pending_q[j]) begin
                found     = 1'b1;
                grant_idx = IW'(j);
            end
        end

        load       = !ev_valid_q || ev_ready;
        grant_mask = (load && found) ? (N_BTN'(1) << grant_idx) : '0;

        // A grant and a new event on the same button leave the bit set: the OR wins.
        pending_d = (pending_q & ~grant_mask) | evt;
        ev_drop_d = |(evt & pending_q & ~grant_mask);

        ev_valid_d = ev_valid_q;
        ev_idx_d   = ev_idx_q;
        rr_ptr_d   = rr_ptr_q;
        if (load) begin
            ev_valid_d = found;
            if (found) begin
                ev_idx_d = grant_idx;
                rr_ptr_d = (grant_idx == IW'(N_BTN - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // btn_q tracks btn through reset so buttons held at reset cannot fire on release.
        btn_q <= btn_d;
        if (rst) begin
            pending_q  <= '0;
            rr_ptr_q   <= '0;
            ev_valid_q <= 1'b0;
            ev_idx_q   <= '0;
            ev_drop_q  <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            rr_ptr_q   <= rr_ptr_d;
            ev_valid_q <= ev_valid_d;
            ev_idx_q   <= ev_idx_d;
            ev_drop_q  <= ev_drop_d;
        end
    end

    assign ev_valid = ev_valid_q;
    assign ev_idx   = ev_idx_q;
    assign ev_drop  = ev_drop_q;

endmodule

// File: tb/tb_button_events.sv
// Directed bench for button_events: edge events, round-robin drain, coalescing,
// reset behaviour and (with BTN_REPEAT_EN) auto-repeat timing.
module tb_button_events;

    logic       clk;
    logic       rst;
    logic [3:0] btn;
    logic       ev_valid;
    logic [1:0] ev_idx;
    logic       ev_ready;
    logic       ev_drop;

    int checks = 0;
    int errors = 0;
    int drop_cnt = 0;
    logic [1:0] got_q[$];
    logic [1:0] exp_q[$];

    button_events #(
        .N_BTN(4),
        .REP_DELAY(10),
        .REP_PERIOD(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn(btn),
        .ev_valid(ev_valid),
        .ev_idx(ev_idx),
        .ev_ready(ev_ready),
        .ev_drop(ev_drop)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after posedge, so negedge values are what the next edge sees.
    always @(negedge clk) begin
        if (!rst && ev_valid && ev_ready) got_q.push_back(ev_idx);
        if (!rst && ev_drop) drop_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
        got_q.delete();
        exp_q.delete();
        drop_cnt = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; btn = 4'b0000; ev_ready = 1'b0;
        step(3);
        checks++;
        if (ev_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", ev_valid); end
        checks++;
        if (ev_idx !== 2'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", ev_idx); end
        checks++;
        if (ev_drop !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b expected 0", ev_drop); end
        rst = 1'b0;
        step(2);
        checks++;
        if (ev_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b expected 0", ev_valid); end
    endtask

    task automatic test_single();
        do_reset();
        ev_ready = 1'b1;
        btn = 4'b0100;
        step(1);
        checks++;
        if (ev_valid !== 1'b0) begin errors++; $display("FAIL single_early: got %b expected 0", ev_valid); end
        btn = 4'b0000;
        step(1);
        checks++;
        if (ev_valid !== 1'b1 || ev_idx !== 2'd2) begin
            errors++; $display("FAIL single_event: got valid=%b idx=%0d expected valid=1 idx=2", ev_valid, ev_idx);
        end
        step(1);
        checks++;
        if (ev_valid !== 1'b0) begin errors++; $display("FAIL single_one_cycle: got %b expected 0", ev_valid); end
        step(3);
        exp_q = '{2'd2};
        checks++;
        if (got_q != exp_q) begin errors++; $display("FAIL single_log: got %p expected %p", got_q, exp_q); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] seq [3];
        seq = '{2'd0, 2'd1, 2'd3};
        do_reset();
        ev_ready = 1'b1;
        btn = 4'b1011;
        step(1);
        for (int k = 0; k < 3; k++) begin
            step(1);
            checks++;
            if (ev_valid !== 1'b1 || ev_idx !== seq[k]) begin
                errors++; $display("FAIL b2b_seq%0d: got valid=%b idx=%0d expected valid=1 idx=%0d", k, ev_valid, ev_idx, seq[k]);
            end
        end
        step(1);
        checks++;
        if (ev_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b expected 0", ev_valid); end
        btn = 4'b0000;
        step(3);
        exp_q = '{2'd0, 2'd1, 2'd3};
        checks++;
        if (got_q != exp_q) begin errors++; $display("FAIL b2b_log: got %p expected %p", got_q, exp_q); end
    endtask

    // Press 1 is presented, press 2 lands in pending[1], press 3 coalesces (one drop).
    // Draining therefore yields the presented event plus the coalesced pending one.
    task automatic test_coalesce();
        do_reset();
        ev_ready = 1'b0;
        for (int p = 0; p < 3; p++) begin
            btn = 4'b0010;
            step(1);
            btn = 4'b0000;
            step(1);
            if (p > 0) begin
                checks++;
                if (ev_valid !== 1'b1 || ev_idx !== 2'd1) begin
                    errors++; $display("FAIL coalesce_hold%0d: got valid=%b idx=%0d expected valid=1 idx=1", p, ev_valid, ev_idx);
                end
            end
        end
        step(1);
        checks++;
        if (drop_cnt !== 1) begin errors++; $display("FAIL coalesce_drop: got %0d expected 1", drop_cnt); end
        ev_ready = 1'b1;
        step(2);
        checks++;
        if (ev_valid !== 1'b0) begin errors++; $display("FAIL coalesce_drain: got %b expected 0", ev_valid); end
        step(2);
        exp_q = '{2'd1, 2'd1};
        checks++;
        if (got_q != exp_q) begin errors++; $display("FAIL coalesce_log: got %p expected %p", got_q, exp_q); end
    endtask

    // New press on button 0 at the very edge its pending bit is granted: bit survives, no drop.
    task automatic test_set_clear();
        do_reset();
        ev_ready = 1'b0;
        btn = 4'b0001; step(1);
        btn = 4'b0000; step(1);
        btn = 4'b0001; step(1);
        btn = 4'b0000; step(1);
        ev_ready = 1'b1;
        btn = 4'b0001; step(1);
        btn = 4'b0000; step(4);
        exp_q = '{2'd0, 2'd0, 2'd0};
        checks++;
        if (got_q != exp_q) begin errors++; $display("FAIL setclr_log: got %p expected %p", got_q, exp_q); end
        checks++;
        if (drop_cnt !== 0) begin errors++; $display("FAIL setclr_drop: got %0d expected 0", drop_cnt); end
    endtask

    task automatic test_held_reset();
        ev_ready = 1'b0;
        btn = 4'b0001;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        got_q.delete();
        step(4);
        checks++;
        if (ev_valid !== 1'b0) begin errors++; $display("FAIL held_reset_valid: got %b expected 0", ev_valid); end
        ev_ready = 1'b1;
        btn = 4'b0000; step(1);
        btn = 4'b0001; step(1);
        btn = 4'b0000; step(1);
        checks++;
        if (ev_valid !== 1'b1 || ev_idx !== 2'd0) begin
            errors++; $display("FAIL held_reset_press: got valid=%b idx=%0d expected valid=1 idx=0", ev_valid, ev_idx);
        end
        step(3);
        exp_q = '{2'd0};
        checks++;
        if (got_q != exp_q) begin errors++; $display("FAIL held_reset_log: got %p expected %p", got_q, exp_q); end
    endtask

    task automatic test_repeat();
        int n_exp;
        do_reset();
        ev_ready = 1'b1;
        btn = 4'b1000;
        step(31);
        btn = 4'b0000;
        step(4);
`ifdef BTN_REPEAT_EN
        n_exp = 7;
`else
        n_exp = 1;
`endif
        for (int k = 0; k < n_exp; k++) exp_q.push_back(2'd3);
        checks++;
        if (got_q != exp_q) begin errors++; $display("FAIL repeat_log: got %p expected %p", got_q, exp_q); end
        checks++;
        if (drop_cnt !== 0) begin errors++; $display("FAIL repeat_drop: got %0d expected 0", drop_cnt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ev_ready = 1'b0;
        btn = 4'b0111;
        step(2);
        checks++;
        if (ev_valid !== 1'b1 || ev_idx !== 2'd0) begin
            errors++; $display("FAIL midrst_pre: got valid=%b idx=%0d expected valid=1 idx=0", ev_valid, ev_idx);
        end
        rst = 1'b1;
        step(1);
        checks++;
        if (ev_valid !== 1'b0) begin errors++; $display("FAIL midrst_in_reset: got %b expected 0", ev_valid); end
        rst = 1'b0;
        ev_ready = 1'b1;
        got_q.delete();
        for (int k = 0; k < 5; k++) begin
            step(1);
            checks++;
            if (ev_valid !== 1'b0) begin errors++; $display("FAIL midrst_after%0d: got %b expected 0", k, ev_valid); end
        end
        checks++;
        if (got_q.size() !== 0) begin errors++; $display("FAIL midrst_log: got %0d events expected 0", got_q.size()); end
        btn = 4'b0000;
    endtask

    initial begin
        rst = 1'b1; btn = 4'b0000; ev_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_coalesce();
        test_set_clear();
        test_held_reset();
        test_repeat();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
